rns_mult_sched: RTL and testbench
=================================

RNS_MULT_SCHED -- requirements
Module: rns_mult_sched

Interface
REQ-001 SHALL have parameter LANES, default 4: slots issued per beat; `N_SLOTS SHALL be a multiple of LANES.
REQ-002 SHALL have parameter MUL_LAT, default 2: pipeline depth of the external modular multiply lanes.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request a full element-wise poly multiply; accepted only when start_ready=1.
REQ-006 SHALL have port basis_sel, input, 2: 0=q, 1=B, 2=Ba; 3=illegal.
REQ-007 SHALL have port start_ready, output, 1: high only in IDLE.
REQ-008 SHALL have port busy, output, 1: high in ISSUE and DRAIN.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port err, output, 1: one-cycle pulse when start is accepted with basis_sel=3.
REQ-011 SHALL have port stall, input, 1: downstream backpressure.
REQ-012 SHALL have ports rd_en (1), rd_slot (SLOT_W), rd_limb (LIMB_W), all outputs: operand fetch beat and its base slot/limb.
REQ-013 SHALL have port mod_sel, output, 2: latched basis_sel, driving modulus selection.
REQ-014 SHALL have ports wr_en (1), wr_slot (SLOT_W), wr_limb (LIMB_W), all outputs: result write-back beat.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE->ISSUE SHALL occur on start with legal basis_sel; basis_sel SHALL be latched into mod_sel.
REQ-017 On start with basis_sel=3, the block SHALL pulse err and stay in IDLE.
REQ-018 Issue order SHALL be limb-major: limb 0..LEN-1 outer, slot 0, LANES, 2*LANES, ... inner; LEN SHALL be the length of the selected basis.
REQ-019 In ISSUE with stall=0, the block SHALL issue one beat per cycle (rd_en=1); after the final beat it SHALL go to DRAIN.
REQ-020 Each beat's wr_en SHALL assert exactly MUL_LAT+1 non-stalled cycles after its rd_en, carrying that beat's slot and limb (valid/index delay line).
REQ-021 While stall=1, rd_en and wr_en SHALL be 0, the issue counters and the delay line SHALL hold, and the FSM SHALL not advance.
REQ-022 DRAIN->DONE SHALL occur in the cycle after the last wr_en; DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 Slot and limb counters SHALL wrap to 0 at `N_SLOTS and at LEN respectively, with no overflow beyond the final beat.

Reset
REQ-025 Asserting rst_n low SHALL, at any time including mid-operation, force IDLE, clear counters and the delay line, set mod_sel=0, and drive all output strobes to 0, with start_ready=1.
REQ-026 No write-back SHALL occur for beats in flight at reset.

Configuration
REQ-027 With RNS_MULT_SCHED_PERF_EN defined: an output perf_cycles, 32-bit, SHALL count cycles with busy=1 (including stalled cycles), clear on accepted start, and saturate at all-ones.
REQ-028 With RNS_MULT_SCHED_PERF_EN undefined: the perf_cycles port and the counter SHALL be absent.

Structure
REQ-029 The basis-length constants, basis_sel encoding, SLOT_W/LIMB_W, and the state enum SHALL reside in the shared types package.
REQ-030 The delay line SHALL be a sub-module, rns_valid_delay, with parameters DEPTH and payload width and a hold input.

Verification (N_SLOTS=8, LANES=4, q_BASIS_LEN=2, MUL_LAT=2; start accepted at cycle 0)
REQ-031 start, basis q -> rd_en at cycles 1-4 with (slot,limb)=(0,0),(4,0),(0,1),(4,1); wr_en at cycles 4-7 with the same indices; done at cycle 8; start_ready at cycle 9.
REQ-032 stall=1 during cycles 2-3 -> no rd_en or wr_en in cycles 2-3; the sequence resumes unchanged; done at cycle 10.
REQ-033 start with basis_sel=3 -> err pulse; start_ready remains 1; no rd_en.
REQ-034 rst_n low at cycle 5 -> immediate IDLE, all strobes 0, no further wr_en; a new start is accepted afterwards.
REQ-035 start held high through completion -> exactly one operation per IDLE visit; a second start is accepted only when start_ready=1.
REQ-036 With PERF_EN defined, case REQ-032 -> perf_cycles=9 after done.

Source files
------------

// File: rtl/rns_mult_sched_pkg.sv
// rtl/rns_mult_sched_pkg.sv - shared types and constants for the RNS multiply scheduler
package rns_mult_sched_pkg;

    localparam int N_SLOTS       = 8;
    localparam int Q_BASIS_LEN   = 2;
    localparam int B_BASIS_LEN   = 3;
    localparam int BA_BASIS_LEN  = 4;
    localparam int MAX_BASIS_LEN = 4;

    localparam int SLOT_W = $clog2(N_SLOTS);
    localparam int LIMB_W = $clog2(MAX_BASIS_LEN);

    typedef enum logic [1:0] {
        BASIS_Q       = 2'd0,
        BASIS_B       = 2'd1,
        BASIS_BA      = 2'd2,
        BASIS_ILLEGAL = 2'd3
    } basis_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [LIMB_W:0] basis_len(input logic [1:0] sel);
        case (sel)
            BASIS_B:  basis_len = (LIMB_W+1)'(B_BASIS_LEN);
            BASIS_BA: basis_len = (LIMB_W+1)'(BA_BASIS_LEN);
            default:  basis_len = (LIMB_W+1)'(Q_BASIS_LEN);
        endcase
    endfunction

endpackage

// File: rtl/rns_mult_sched_delay.sv
// rtl/rns_mult_sched_delay.sv - rns_valid_delay: holdable valid/payload delay line
module rns_valid_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         pending
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else if (!hold) begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

    // Beats still upstream of the output stage; used to spot the final write-back.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | vld_q[i];
    end

endmodule

// File: rtl/rns_mult_sched.sv
// rtl/rns_mult_sched.sv - limb-major RNS element-wise multiply scheduler; RNS_MULT_SCHED_PERF_EN adds perf_cycles
module rns_mult_sched
    import rns_mult_sched_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        basis_sel,
    output logic              start_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              stall,
    output logic              rd_en,
    output logic [SLOT_W-1:0] rd_slot,
    output logic [LIMB_W-1:0] rd_limb,
    output logic [1:0]        mod_sel,
    output logic              wr_en,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [LIMB_W-1:0] wr_limb
`ifdef RNS_MULT_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    state_e state_q, state_d;

    logic [SLOT_W-1:0] slot_q;
    logic [LIMB_W-1:0] limb_q;
    logic [1:0]        mod_sel_q;
    logic              err_q;
    logic [LIMB_W:0]   len;
    logic              slot_last, limb_last, last_beat, start_acc;
    logic              dly_valid, dly_pending;
    logic [SLOT_W+LIMB_W-1:0] dly_data;

    assign len       = basis_len(mod_sel_q);
    assign slot_last = (slot_q == SLOT_W'(N_SLOTS - LANES));
    assign limb_last = ({1'b0, limb_q} == len - (LIMB_W+1)'(1));
    assign last_beat = slot_last && limb_last;
    assign start_acc = (state_q == S_IDLE) && start && (basis_sel != BASIS_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_ISSUE;
            S_ISSUE: if (rd_en && last_beat) state_d = S_DRAIN;
            S_DRAIN: if (wr_en && !dly_pending) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == S_IDLE);
        busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        rd_en       = (state_q == S_ISSUE) && !stall;
        wr_en       = dly_valid && !stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            limb_q    <= '0;
            mod_sel_q <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && start && (basis_sel == BASIS_ILLEGAL);
            if (start_acc) begin
                mod_sel_q <= basis_sel;
                slot_q    <= '0;
                limb_q    <= '0;
            end else if (rd_en) begin
                if (slot_last) begin
                    slot_q <= '0;
                    limb_q <= limb_last ? '0 : limb_q + LIMB_W'(1);
                end else begin
                    slot_q <= slot_q + SLOT_W'(LANES);
                end
            end
        end
    end

    // MUL_LAT multiplier stages plus the operand fetch stage.
    rns_valid_delay #(
        .DEPTH (MUL_LAT + 1),
        .W     (SLOT_W + LIMB_W)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (stall),
        .in_valid  (rd_en),
        .in_data   ({slot_q, limb_q}),
        .out_valid (dly_valid),
        .out_data  (dly_data),
        .pending   (dly_pending)
    );

    assign rd_slot = slot_q;
    assign rd_limb = limb_q;
    assign wr_slot = dly_data[SLOT_W+LIMB_W-1:LIMB_W];
    assign wr_limb = dly_data[LIMB_W-1:0];
    assign mod_sel = mod_sel_q;
    assign err     = err_q;

`ifdef RNS_MULT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          perf_cycles <= '0;
        else if (start_acc)                  perf_cycles <= '0;
        else if (busy && perf_cycles != '1)  perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_rns_mult_sched.sv
// tb/tb_rns_mult_sched.sv - table-driven self-checking bench for rns_mult_sched
module tb_rns_mult_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] basis_sel = 2'd0;
    logic       stall = 1'b0;
    logic       start_ready, busy, done, err, rd_en, wr_en;
    logic [2:0] rd_slot, wr_slot;
    logic [1:0] rd_limb, wr_limb, mod_sel;
`ifdef RNS_MULT_SCHED_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    rns_mult_sched #(.LANES(4), .MUL_LAT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .basis_sel   (basis_sel),
        .start_ready (start_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .stall       (stall),
        .rd_en       (rd_en),
        .rd_slot     (rd_slot),
        .rd_limb     (rd_limb),
        .mod_sel     (mod_sel),
        .wr_en       (wr_en),
        .wr_slot     (wr_slot),
        .wr_limb     (wr_limb)
`ifdef RNS_MULT_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic        stall;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic s, logic st, logic rd, int rs, int rl,
                               logic wr, int ws, int wl, logic dn, logic rdy, logic bsy);
        vec_t r;
        r.start = s;
        r.stall = st;
        r.exp   = {rd, 3'(rs), 2'(rl), wr, 3'(ws), 2'(wl), dn, rdy, bsy};
        return r;
    endfunction

    function automatic logic [14:0] obs();
        return {rd_en, rd_en ? rd_slot : 3'd0, rd_en ? rd_limb : 2'd0,
                wr_en, wr_en ? wr_slot : 3'd0, wr_en ? wr_limb : 2'd0,
                done, start_ready, busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, expv);
        end
    endtask

    task automatic step(input logic s, input logic st, input logic [1:0] sel);
        @(posedge clk);
        #1;
        start     = s;
        stall     = st;
        basis_sel = sel;
        @(negedge clk);
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].start, tbl[i].stall, 2'd0);
            chk($sformatf("%s_c%0d", nm, i), {17'd0, obs()}, {17'd0, tbl[i].exp});
        end
    endtask

    task automatic fill_plain();
        tbl.delete();
        tbl.push_back(v(1,0, 0,0,0, 0,0,0, 0,1,0));
        tbl.push_back(v(0,0, 1,0,0, 0,0,0, 0,0,1));
        tbl.push_back(v(0,0, 1,4,0, 0,0,0, 0,0,1));
        tbl.push_back(v(0,0, 1,0,1, 0,0,0, 0,0,1));
        tbl.push_back(v(0,0, 1,4,1, 1,0,0, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 1,4,0, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 1,0,1, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 1,4,1, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 0,0,0, 1,0,0));
        tbl.push_back(v(0,0, 0,0,0, 0,0,0, 0,1,0));
    endtask

    task automatic fill_stall();
        tbl.delete();
        tbl.push_back(v(1,0, 0,0,0, 0,0,0, 0,1,0));
        tbl.push_back(v(0,0, 1,0,0, 0,0,0, 0,0,1));
        tbl.push_back(v(0,1, 0,0,0, 0,0,0, 0,0,1));
        tbl.push_back(v(0,1, 0,0,0, 0,0,0, 0,0,1));
        tbl.push_back(v(0,0, 1,4,0, 0,0,0, 0,0,1));
        tbl.push_back(v(0,0, 1,0,1, 0,0,0, 0,0,1));
        tbl.push_back(v(0,0, 1,4,1, 1,0,0, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 1,4,0, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 1,0,1, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 1,4,1, 0,0,1));
        tbl.push_back(v(0,0, 0,0,0, 0,0,0, 1,0,0));
        tbl.push_back(v(0,0, 0,0,0, 0,0,0, 0,1,0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt, dn_cnt, rdy_cnt, dn_cyc, wr_cnt;
        int lens[2];
        lens[0] = 3;
        lens[1] = 4;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {25'd0, start_ready, busy, rd_en, wr_en, done, err, mod_sel},
            {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0);

        fill_plain();
        run_tbl("plain");

        fill_stall();
        run_tbl("stall");
`ifdef RNS_MULT_SCHED_PERF_EN
        chk("perf_cycles", perf_cycles, 32'd9);
`endif

        step(1, 0, 3);
        chk("err_c0_ready", {31'd0, start_ready}, 32'd1);
        step(0, 0, 0);
        chk("err_c1", {28'd0, err, start_ready, rd_en, busy}, {28'd0, 4'b1100});
        step(0, 0, 0);
        chk("err_c2", {28'd0, err, start_ready, rd_en, busy}, {28'd0, 4'b0100});

        for (int k = 0; k < 2; k++) begin
            rd_cnt = 0;
            dn_cyc = -1;
            step(1, 0, 2'(k + 1));
            for (int c = 1; c <= 2 * lens[k] + 5; c++) begin
                step(0, 0, 0);
                if (c == 1) chk($sformatf("mod_sel_%0d", k + 1), {30'd0, mod_sel}, k + 1);
                if (rd_en) rd_cnt++;
                if (done && dn_cyc < 0) dn_cyc = c;
            end
            chk($sformatf("beats_sel%0d", k + 1), rd_cnt, 2 * lens[k]);
            chk($sformatf("done_cyc_sel%0d", k + 1), dn_cyc, 2 * lens[k] + 4);
        end

        rd_cnt = 0; dn_cnt = 0; rdy_cnt = 0;
        for (int c = 0; c < 18; c++) begin
            step(1, 0, 0);
            if (rd_en) rd_cnt++;
            if (done) dn_cnt++;
            if (start_ready) rdy_cnt++;
        end
        step(0, 0, 0);
        step(0, 0, 0);
        chk("held_start_beats", rd_cnt, 8);
        chk("held_start_dones", dn_cnt, 2);
        chk("held_start_accepts", rdy_cnt, 2);

        step(1, 0, 1);
        for (int c = 1; c <= 4; c++) step(0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midop_reset", {25'd0, start_ready, busy, rd_en, wr_en, done, err, mod_sel},
            {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        wr_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 0);
            if (wr_en || busy) wr_cnt++;
        end
        chk("no_wr_after_reset", wr_cnt, 0);

        fill_plain();
        run_tbl("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
